ulpb_tx_arbiter: RTL and testbench
==================================

ULPB_TX_ARBITER -- requirements
Module: ulpb_tx_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, 4, number of requesters; ADDR_WIDTH/DATA_WIDTH, from include/ulpb_def.v (8/32).
REQ-002 SHALL have ports: CLKIN  in  1  clock; RESETn  in  1  async active-low reset.
REQ-003 SHALL have: REQ_TX_ADDR  in  NUM_REQ*8  packed per-requester address, slot i at [8i+7:8i].
REQ-004 SHALL have: REQ_TX_DATA  in  NUM_REQ*32  packed per-requester data.
REQ-005 SHALL have: REQ_TX_REQ, REQ_TX_PEND, REQ_PRIORITY, REQ_TX_RESP_ACK  in  NUM_REQ each  per-requester handshake inputs.
REQ-006 SHALL have: REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL  out  NUM_REQ each  per-requester handshake returns.
REQ-007 SHALL have bus side: TX_ADDR out 8, TX_DATA out 32, TX_REQ/TX_PEND/PRIORITY/TX_RESP_ACK out 1, toward node; TX_ACK/TX_SUCC/TX_FAIL in 1, from node.
REQ-008 SHALL have: GRANT  out  NUM_REQ  one-hot registered owner; BUSY  out  1  registered, high when state != IDLE.

Function
REQ-009 SHALL implement states IDLE, XFER, RESP_WAIT, RESP_REL; unused encodings SHALL return to IDLE next edge with GRANT=0.
REQ-010 IDLE: if any REQ_TX_REQ high, SHALL select winner at that edge, register GRANT, go XFER; winner visible on bus the following cycle (1-cycle arbitration latency).
REQ-011 Selection: among requesters with REQ_TX_REQ&REQ_PRIORITY, else among all with REQ_TX_REQ; round-robin starting at index (LAST+1) mod NUM_REQ, LAST = previous winner.
REQ-012 XFER: bus TX_ADDR/TX_DATA/TX_REQ/TX_PEND/PRIORITY SHALL combinationally mirror granted slot; REQ_TX_ACK[g]=TX_ACK.
REQ-013 Grant SHALL be held across all words of a TX_PEND=1 message; no other requester's fields reach the bus until return to IDLE.
REQ-014 XFER -> RESP_WAIT when TX_SUCC or TX_FAIL sampled high (including mid-message fail).
REQ-015 RESP_WAIT/RESP_REL: REQ_TX_SUCC[g]=TX_SUCC, REQ_TX_FAIL[g]=TX_FAIL, TX_RESP_ACK=REQ_TX_RESP_ACK[g]; bus TX_REQ forced 0.
REQ-016 RESP_WAIT -> RESP_REL when REQ_TX_RESP_ACK[g] high; RESP_REL -> IDLE when TX_SUCC, TX_FAIL and REQ_TX_RESP_ACK[g] all low; LAST<=g, GRANT<=0 at that edge.
REQ-017 After return to IDLE SHALL spend at least one cycle in IDLE before next grant.
REQ-018 Non-granted slots' REQ_TX_ACK/SUCC/FAIL SHALL be 0; with GRANT=0 all bus outputs SHALL be 0.
REQ-019 Requester dropping REQ_TX_REQ mid-message SHALL NOT release grant; only completion per REQ-016 releases.
REQ-020 TX_SUCC and TX_FAIL both high SHALL be forwarded unchanged; arbiter does not resolve.

Reset
REQ-021 RESETn low SHALL asynchronously force state IDLE, GRANT=0, BUSY=0, LAST=NUM_REQ-1, all bus and per-requester outputs 0, including mid-transfer.
REQ-022 After reset release, requester 0 SHALL win first tie among equal-class requesters.

Verification
REQ-023 REQ_TX_REQ=0010, addr 0x12, data 0xDEADBEEF, PEND=0 -> GRANT=0010 next edge, TX_ADDR=0x12, TX_DATA=0xDEADBEEF; TX_ACK -> REQ_TX_ACK=0010; TX_SUCC -> REQ_TX_SUCC=0010; after resp-ack release GRANT=0000, BUSY=0.
REQ-024 After reset, REQ_TX_REQ=0101 held, no priority -> grants 0001 then 0100, then 0001 again (round-robin).
REQ-025 REQ_TX_REQ=1001, REQ_PRIORITY=1000 -> GRANT=1000 first despite pointer favouring 0.
REQ-026 Requester 2 sends 3 words PEND=1,1,0; requester 1 asserts during word 2 -> bus shows only slot 2 fields until RESP_REL exit, then GRANT=0010 after one idle cycle.
REQ-027 TX_FAIL during word 1 of multi-word -> REQ_TX_FAIL[g]=1, TX_REQ=0, completion via RESP_WAIT/RESP_REL.
REQ-028 RESETn low during XFER with TX_REQ=1 -> TX_REQ, GRANT, BUSY, REQ_TX_ACK all 0 without clock edge.

Source files
------------

// File: rtl/ulpb_tx_arbiter.sv
// ulpb_tx_arbiter: grants one of NUM_REQ transmit requesters access to a single bus node
// Ports:
//   CLKIN, RESETn                      clock, asynchronous active-low reset
//   REQ_TX_ADDR/DATA                   packed per-requester address/data, slot i at [W*i +: W]
//   REQ_TX_REQ/PEND/PRIORITY/RESP_ACK  per-requester handshake inputs
//   REQ_TX_ACK/SUCC/FAIL               per-requester handshake returns, only the granted slot is live
//   TX_ADDR/DATA/REQ/PEND/PRIORITY     bus fields toward the node, mirrored from the granted slot
//   TX_RESP_ACK                        granted requester's response acknowledge toward the node
//   TX_ACK/SUCC/FAIL                   node handshake returns
//   GRANT, BUSY                        registered one-hot owner, high when not idle
module ulpb_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          CLKIN,
    input  logic                          RESETn,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_TX_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_TX_DATA,
    input  logic [NUM_REQ-1:0]            REQ_TX_REQ,
    input  logic [NUM_REQ-1:0]            REQ_TX_PEND,
    input  logic [NUM_REQ-1:0]            REQ_PRIORITY,
    input  logic [NUM_REQ-1:0]            REQ_TX_RESP_ACK,
    output logic [NUM_REQ-1:0]            REQ_TX_ACK,
    output logic [NUM_REQ-1:0]            REQ_TX_SUCC,
    output logic [NUM_REQ-1:0]            REQ_TX_FAIL,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_REQ,
    output logic                          TX_PEND,
    output logic                          PRIORITY,
    output logic                          TX_RESP_ACK,
    input  logic                          TX_ACK,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    output logic [NUM_REQ-1:0]            GRANT,
    output logic                          BUSY
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, XFER, RESP_WAIT, RESP_REL} state_t;

    state_t            state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, cand;
    logic [IW-1:0]     gidx_q, gidx_d, last_q, last_d, win_idx;
    logic              busy_q, win_found, sel, in_xfer, in_resp;

    // Priority requesters form their own class; round-robin starts just after the last winner.
    always_comb begin
        cand      = |(REQ_TX_REQ & REQ_PRIORITY) ? (REQ_TX_REQ & REQ_PRIORITY) : REQ_TX_REQ;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && cand[(int'(last_q) + i) % NUM_REQ]) begin
                win_idx   = IW'((int'(last_q) + i) % NUM_REQ);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (win_found) begin
                state_d = XFER;
                grant_d = NUM_REQ'(1) << win_idx;
                gidx_d  = win_idx;
            end
            XFER: if (TX_SUCC || TX_FAIL) state_d = RESP_WAIT;
            RESP_WAIT: if (REQ_TX_RESP_ACK[gidx_q]) state_d = RESP_REL;
            RESP_REL: if (!TX_SUCC && !TX_FAIL && !REQ_TX_RESP_ACK[gidx_q]) begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = gidx_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            busy_q  <= state_d != IDLE;
        end
    end

    // Everything toward the bus is gated by the registered grant, so reset clears it instantly.
    assign sel         = |grant_q;
    assign in_xfer     = state_q == XFER;
    assign in_resp     = state_q == RESP_WAIT || state_q == RESP_REL;
    assign TX_ADDR     = sel ? REQ_TX_ADDR[gidx_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign TX_DATA     = sel ? REQ_TX_DATA[gidx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign TX_REQ      = sel && in_xfer && REQ_TX_REQ[gidx_q];
    assign TX_PEND     = sel && REQ_TX_PEND[gidx_q];
    assign PRIORITY    = sel && REQ_PRIORITY[gidx_q];
    assign TX_RESP_ACK = sel && in_resp && REQ_TX_RESP_ACK[gidx_q];
    assign REQ_TX_ACK  = (in_xfer && TX_ACK) ? grant_q : '0;
    assign REQ_TX_SUCC = (in_resp && TX_SUCC) ? grant_q : '0;
    assign REQ_TX_FAIL = (in_resp && TX_FAIL) ? grant_q : '0;
    assign GRANT       = grant_q;
    assign BUSY        = busy_q;
endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// tb_ulpb_tx_arbiter: directed self-checking bench for ulpb_tx_arbiter
module tb_ulpb_tx_arbiter;
    logic        CLKIN = 1'b0;
    logic        RESETn;
    logic [31:0] REQ_TX_ADDR;
    logic [127:0] REQ_TX_DATA;
    logic [3:0]  REQ_TX_REQ, REQ_TX_PEND, REQ_PRIORITY, REQ_TX_RESP_ACK;
    logic [3:0]  REQ_TX_ACK, REQ_TX_SUCC, REQ_TX_FAIL, GRANT;
    logic [7:0]  TX_ADDR;
    logic [31:0] TX_DATA;
    logic        TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK, TX_ACK, TX_SUCC, TX_FAIL, BUSY;
    int          checks = 0;
    int          errors = 0;

    ulpb_tx_arbiter dut (
        .CLKIN(CLKIN), .RESETn(RESETn),
        .REQ_TX_ADDR(REQ_TX_ADDR), .REQ_TX_DATA(REQ_TX_DATA),
        .REQ_TX_REQ(REQ_TX_REQ), .REQ_TX_PEND(REQ_TX_PEND),
        .REQ_PRIORITY(REQ_PRIORITY), .REQ_TX_RESP_ACK(REQ_TX_RESP_ACK),
        .REQ_TX_ACK(REQ_TX_ACK), .REQ_TX_SUCC(REQ_TX_SUCC), .REQ_TX_FAIL(REQ_TX_FAIL),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
        .PRIORITY(PRIORITY), .TX_RESP_ACK(TX_RESP_ACK),
        .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
        .GRANT(GRANT), .BUSY(BUSY)
    );

    always #5 CLKIN = ~CLKIN;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        REQ_TX_ADDR = '0; REQ_TX_DATA = '0; REQ_TX_REQ = '0; REQ_TX_PEND = '0;
        REQ_PRIORITY = '0; REQ_TX_RESP_ACK = '0; TX_ACK = 0; TX_SUCC = 0; TX_FAIL = 0;
        repeat (2) step();
        RESETn = 1'b1;
        step();
    endtask

    task automatic finish_resp(input int g, input logic fail);
        TX_SUCC = !fail; TX_FAIL = fail;
        step();
        REQ_TX_RESP_ACK[g] = 1'b1;
        step();
        TX_SUCC = 0; TX_FAIL = 0; REQ_TX_RESP_ACK = '0;
        step();
    endtask

    initial begin
        do_reset();
        check("rst_grant", GRANT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_txreq", TX_REQ, 0);

        REQ_TX_ADDR[15:8] = 8'h12; REQ_TX_DATA[63:32] = 32'hDEADBEEF; REQ_TX_REQ = 4'b0010;
        #1 check("single_idle_grant", GRANT, 0);
        step();
        check("single_grant", GRANT, 4'b0010);
        check("single_busy", BUSY, 1);
        check("single_addr", TX_ADDR, 8'h12);
        check("single_data", TX_DATA, 32'hDEADBEEF);
        check("single_txreq", TX_REQ, 1);
        TX_ACK = 1;
        #1 check("single_ack", REQ_TX_ACK, 4'b0010);
        TX_ACK = 0; REQ_TX_REQ = '0; TX_SUCC = 1;
        step();
        check("single_succ", REQ_TX_SUCC, 4'b0010);
        check("single_resp_txreq", TX_REQ, 0);
        REQ_TX_RESP_ACK[1] = 1;
        #1 check("single_resp_ack", TX_RESP_ACK, 1);
        step();
        TX_SUCC = 0;
        step();
        check("single_rel_hold", GRANT, 4'b0010);
        REQ_TX_RESP_ACK = '0;
        step();
        check("single_done_grant", GRANT, 0);
        check("single_done_busy", BUSY, 0);

        do_reset();
        REQ_TX_REQ = 4'b0101;
        step();
        check("rr_first", GRANT, 4'b0001);
        finish_resp(0, 0);
        check("rr_idle_gap", GRANT, 0);
        step();
        check("rr_second", GRANT, 4'b0100);
        finish_resp(2, 0);
        step();
        check("rr_third", GRANT, 4'b0001);
        REQ_TX_REQ = '0;
        finish_resp(0, 0);

        do_reset();
        REQ_TX_REQ = 4'b1001; REQ_PRIORITY = 4'b1000;
        step();
        check("prio_grant", GRANT, 4'b1000);
        check("prio_bus", PRIORITY, 1);
        REQ_TX_REQ = '0; REQ_PRIORITY = '0;
        finish_resp(3, 0);

        REQ_TX_ADDR = '0; REQ_TX_DATA = '0;
        REQ_TX_ADDR[23:16] = 8'h22; REQ_TX_ADDR[15:8] = 8'h11;
        REQ_TX_DATA[95:64] = 32'h20000001; REQ_TX_DATA[63:32] = 32'h10000001;
        REQ_TX_REQ = 4'b0100; REQ_TX_PEND = 4'b0100;
        step();
        check("msg_grant", GRANT, 4'b0100);
        check("msg_addr", TX_ADDR, 8'h22);
        check("msg_pend", TX_PEND, 1);
        TX_ACK = 1;
        #1 check("msg_ack", REQ_TX_ACK, 4'b0100);
        step();
        TX_ACK = 0; REQ_TX_DATA[95:64] = 32'h20000002; REQ_TX_REQ = 4'b0110;
        #1 check("msg_w2_data", TX_DATA, 32'h20000002);
        check("msg_w2_addr", TX_ADDR, 8'h22);
        step();
        check("msg_w2_grant", GRANT, 4'b0100);
        REQ_TX_DATA[95:64] = 32'h20000003; REQ_TX_PEND = '0; REQ_TX_REQ = 4'b0010;
        #1 check("msg_w3_pend", TX_PEND, 0);
        check("msg_w3_data", TX_DATA, 32'h20000003);
        step();
        check("msg_drop_hold", GRANT, 4'b0100);
        finish_resp(2, 0);
        check("msg_idle_grant", GRANT, 0);
        check("msg_idle_addr", TX_ADDR, 0);
        step();
        check("msg_next_grant", GRANT, 4'b0010);
        check("msg_next_addr", TX_ADDR, 8'h11);
        REQ_TX_REQ = '0;
        finish_resp(1, 0);

        REQ_TX_REQ = 4'b1000; REQ_TX_PEND = 4'b1000;
        step();
        check("fail_grant", GRANT, 4'b1000);
        TX_FAIL = 1;
        step();
        check("fail_fwd", REQ_TX_FAIL, 4'b1000);
        check("fail_txreq", TX_REQ, 0);
        check("fail_no_succ", REQ_TX_SUCC, 0);
        TX_SUCC = 1;
        #1 check("both_succ", REQ_TX_SUCC, 4'b1000);
        check("both_fail", REQ_TX_FAIL, 4'b1000);
        REQ_TX_RESP_ACK[3] = 1;
        step();
        TX_SUCC = 0; TX_FAIL = 0; REQ_TX_RESP_ACK = '0; REQ_TX_REQ = '0; REQ_TX_PEND = '0;
        step();
        check("fail_done_busy", BUSY, 0);
        check("fail_done_grant", GRANT, 0);

        REQ_TX_REQ = 4'b0001;
        step();
        TX_ACK = 1;
        #1 check("ar_txreq_pre", TX_REQ, 1);
        #1 RESETn = 0;
        #1 check("ar_txreq", TX_REQ, 0);
        check("ar_grant", GRANT, 0);
        check("ar_busy", BUSY, 0);
        check("ar_ack", REQ_TX_ACK, 0);
        RESETn = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
